hack_memory_map: RTL

Parametrised data-memory subsystem for the Hack CPU on the iCE40 UP5K, built from SB_SPRAM256KA banks. It decodes the CPU data address into general RAM (one or more 16K-word banks), a screen buffer in its own SPRAM bank, a latched keyboard register and an unmapped region. A second read-only port lets the video scanout fetch screen words. That port is arbitrated against the CPU, with a bounded-starvation guarantee. Read data on both ports is registered, with fixed latency.

---
 rtl/hack_memory_map_if.sv | 29 ++
 rtl/hack_memory_map.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hack_memory_map_if.sv
// Hack data-memory bus: CPU data port, video scanout read port and keyboard front-end feed.
interface hack_memory_map_if #(
   parameter int ADDR_WIDTH = 15
);
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [15:0]           cpu_wdata;
   logic                  cpu_we;
   logic                  cpu_re;
   logic                  cpu_ready;
   logic [15:0]           cpu_rdata;
   logic                  cpu_rvalid;
   logic                  cpu_err;
   logic                  vid_req;
   logic [12:0]           vid_addr;
   logic                  vid_ack;
   logic [15:0]           vid_rdata;
   logic [15:0]           kbd_code;
   logic                  kbd_strobe;

   modport master (
      output cpu_addr, cpu_wdata, cpu_we, cpu_re, vid_req, vid_addr, kbd_code, kbd_strobe,
      input  cpu_ready, cpu_rdata, cpu_rvalid, cpu_err, vid_ack, vid_rdata
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_we, cpu_re, vid_req, vid_addr, kbd_code, kbd_strobe,
      output cpu_ready, cpu_rdata, cpu_rvalid, cpu_err, vid_ack, vid_rdata
   );
endinterface

// File: rtl/hack_memory_map.sv
// Hack CPU data memory: SPRAM general RAM banks, screen bank shared with video scanout,
// latched keyboard register and unmapped region, all with one-cycle registered reads.

// Behavioural 16K x 16 single-port RAM matching the SB_SPRAM256KA data path.
module hack_spram (
   input  logic        clk,
   input  logic [13:0] addr,
   input  logic [15:0] din,
   input  logic [3:0]  maskwren,
   input  logic        wren,
   input  logic        cs,
   output logic [15:0] dout
);
   logic [15:0] mem_r [16384];

   // Nibble-masked write, registered read; output holds between reads.
   always_ff @(posedge clk) begin
      if (cs) begin
         if (wren) begin
            for (int n = 0; n < 4; n++) begin
               if (maskwren[n]) begin
                  mem_r[addr][4*n +: 4] <= din[4*n +: 4];
               end
            end
         end else begin
            dout <= mem_r[addr];
         end
      end
   end
endmodule

module hack_memory_map #(
   parameter int RAM_BANKS  = 1,
   parameter int ADDR_WIDTH = 15,
   parameter int STARVE_MAX = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   hack_memory_map_if.slave    bus
);
   localparam int SCREEN_BASE = RAM_BANKS * 16384;
   localparam int KBD_ADDR    = SCREEN_BASE + 8192;
   localparam int BW          = ADDR_WIDTH - 14;
   localparam int SW          = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      REG_RAM = 2'd0,
      REG_SCR = 2'd1,
      REG_KBD = 2'd2,
      REG_UNM = 2'd3
   } region_t;

   region_t        region_s;
   region_t        rsel_r;
   logic [31:0]    addr_ext_s;
   logic [BW-1:0]  bank_s;
   logic [BW-1:0]  rbank_r;
   logic           cpu_acc_s;
   logic           cpu_rd_s;
   logic           cpu_scr_s;
   logic           starving_s;
   logic           vid_grant_s;
   logic           cpu_ready_s;
   logic           accept_s;
   logic [SW-1:0]  starve_r;
   logic [15:0]    kbd_r;
   logic [15:0]    kbd_snap_r;
   logic           rvalid_r;
   logic           err_r;
   logic           vid_ack_r;
   logic [15:0]    cpu_hold_r;
   logic [15:0]    vid_hold_r;
   logic [15:0]    ram_dout_s [RAM_BANKS];
   logic [15:0]    ram_sel_dout_s;
   logic [15:0]    rd_mux_s;
   logic [15:0]    scr_dout_s;
   logic [13:0]    scr_addr_s;
   logic           scr_cs_s;
   logic           scr_wren_s;

   assign addr_ext_s = 32'(bus.cpu_addr);
   assign bank_s     = bus.cpu_addr[ADDR_WIDTH-1:14];

   // Address decode into the four regions.
   always_comb begin
      region_s = REG_UNM;
      if (addr_ext_s < 32'(SCREEN_BASE)) begin
         region_s = REG_RAM;
      end else if (addr_ext_s < 32'(KBD_ADDR)) begin
         region_s = REG_SCR;
      end else if (addr_ext_s == 32'(KBD_ADDR)) begin
         region_s = REG_KBD;
      end else begin
         region_s = REG_UNM;
      end
   end

   // A write wins when both we and re are raised, so only pure reads produce data.
   assign cpu_acc_s   = bus.cpu_we | bus.cpu_re;
   assign cpu_rd_s    = bus.cpu_re & ~bus.cpu_we;
   assign cpu_scr_s   = cpu_acc_s & (region_s == REG_SCR);
   assign starving_s  = (starve_r == STARVE_TOP);
   assign vid_grant_s = bus.vid_req & (~cpu_scr_s | starving_s);
   assign cpu_ready_s = ~(cpu_scr_s & vid_grant_s);
   assign accept_s    = cpu_acc_s & cpu_ready_s;

   assign bus.cpu_ready = cpu_ready_s;

   // Starvation counter: counts refused video cycles, saturating at STARVE_MAX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_r <= '0;
      end else if (!bus.vid_req || vid_grant_s) begin
         starve_r <= '0;
      end else if (cpu_scr_s && !starving_s) begin
         starve_r <= starve_r + SW'(1);
      end else begin
         starve_r <= starve_r;
      end
   end

   for (genvar g = 0; g < RAM_BANKS; g++) begin : g_ram
      logic sel_s;
      assign sel_s = accept_s & (region_s == REG_RAM) & (bank_s == BW'(g));
      hack_spram u_ram (
         .clk      (clk),
         .addr     (bus.cpu_addr[13:0]),
         .din      (bus.cpu_wdata),
         .maskwren (4'b1111),
         .wren     (bus.cpu_we),
         .cs       (sel_s),
         .dout     (ram_dout_s[g])
      );
   end

   // Screen bank port steering: video owns the port whenever it is granted.
   always_comb begin
      scr_cs_s   = vid_grant_s | (cpu_scr_s & cpu_ready_s);
      scr_wren_s = 1'b0;
      scr_addr_s = {1'b0, bus.cpu_addr[12:0]};
      if (vid_grant_s) begin
         scr_addr_s = {1'b0, bus.vid_addr};
      end else begin
         scr_wren_s = bus.cpu_we;
      end
   end

   hack_spram u_screen (
      .clk      (clk),
      .addr     (scr_addr_s),
      .din      (bus.cpu_wdata),
      .maskwren (4'b1111),
      .wren     (scr_wren_s),
      .cs       (scr_cs_s),
      .dout     (scr_dout_s)
   );

   // Keyboard latch: a strobe beats a simultaneous CPU clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kbd_r <= 16'h0000;
      end else if (bus.kbd_strobe) begin
         kbd_r <= bus.kbd_code;
      end else if (accept_s && bus.cpu_we && (region_s == REG_KBD)) begin
         kbd_r <= 16'h0000;
      end else begin
         kbd_r <= kbd_r;
      end
   end

   // Read-select pipeline and response pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_r   <= 1'b0;
         err_r      <= 1'b0;
         vid_ack_r  <= 1'b0;
         rsel_r     <= REG_RAM;
         rbank_r    <= '0;
         kbd_snap_r <= 16'h0000;
      end else begin
         rvalid_r  <= accept_s & cpu_rd_s;
         err_r     <= accept_s & (region_s == REG_UNM);
         vid_ack_r <= vid_grant_s;
         if (accept_s && cpu_rd_s) begin
            rsel_r     <= region_s;
            rbank_r    <= bank_s;
            kbd_snap_r <= kbd_r;
         end else begin
            rsel_r     <= rsel_r;
            rbank_r    <= rbank_r;
            kbd_snap_r <= kbd_snap_r;
         end
      end
   end

   // Return-data mux driven purely by the registered select.
   always_comb begin
      ram_sel_dout_s = 16'h0000;
      for (int i = 0; i < RAM_BANKS; i++) begin
         ram_sel_dout_s = ram_sel_dout_s | ({16{rbank_r == BW'(i)}} & ram_dout_s[i]);
      end
      case (rsel_r)
         REG_RAM: rd_mux_s = ram_sel_dout_s;
         REG_SCR: rd_mux_s = scr_dout_s;
         REG_KBD: rd_mux_s = kbd_snap_r;
         default: rd_mux_s = 16'h0000;
      endcase
   end

   // Hold registers keep read data stable once the response pulse has passed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_hold_r <= 16'h0000;
         vid_hold_r <= 16'h0000;
      end else begin
         cpu_hold_r <= rvalid_r ? rd_mux_s : cpu_hold_r;
         vid_hold_r <= vid_ack_r ? scr_dout_s : vid_hold_r;
      end
   end

   assign bus.cpu_rvalid = rvalid_r;
   assign bus.cpu_err    = err_r;
   assign bus.cpu_rdata  = rvalid_r ? rd_mux_s : cpu_hold_r;
   assign bus.vid_ack    = vid_ack_r;
   assign bus.vid_rdata  = vid_ack_r ? scr_dout_s : vid_hold_r;
endmodule
